// File: rtl/uart_rx_pkt_ctrl_if.sv
// Byte-stream interface around the receive packet controller: the receiver
// strobe side, the downstream valid/ready payload stream, and the status pulses.
interface uart_rx_pkt_ctrl_if;
    // Receiver side: one-cycle byte strobes.
    logic       i_Rx_DV;
    logic [7:0] i_Rx_Byte;

    // Downstream payload stream.
    logic       o_Pkt_Valid;
    logic [7:0] o_Pkt_Byte;
    logic       o_Pkt_Last;
    logic       i_Pkt_Ready;
    logic [7:0] o_Pkt_Len;

    // Status and error pulses.
    logic       o_Busy;
    logic       o_Err_Len;
    logic       o_Err_Chk;
    logic       o_Err_Timeout;
    logic       o_Drop;

    // Controller view: consumes strobes and ready, drives stream and status.
    modport master (
        input  i_Rx_DV, i_Rx_Byte, i_Pkt_Ready,
        output o_Pkt_Valid, o_Pkt_Byte, o_Pkt_Last, o_Pkt_Len,
               o_Busy, o_Err_Len, o_Err_Chk, o_Err_Timeout, o_Drop
    );

    // Environment view: the receiver plus the downstream consumer.
    modport slave (
        output i_Rx_DV, i_Rx_Byte, i_Pkt_Ready,
        input  o_Pkt_Valid, o_Pkt_Byte, o_Pkt_Last, o_Pkt_Len,
               o_Busy, o_Err_Len, o_Err_Chk, o_Err_Timeout, o_Drop
    );
endinterface

// File: rtl/uart_rx_pkt_ctrl.sv
// Receive-side packet controller. Frames UART byte strobes into
// SYNC, LEN, payload, CHK packets, buffers the payload, and replays validated
// packets over a valid/ready byte stream. Bad length, bad checksum and
// inter-byte stalls discard the packet with a one-cycle error pulse.
module uart_rx_pkt_ctrl #(
    parameter int unsigned MAX_LEN      = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 3480
) (
    input logic                i_Clock,
    input logic                i_Rst_L,
    uart_rx_pkt_ctrl_if.master bus
);

    // Buffer index width; a one-entry buffer still needs a one-bit index.
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    // The counter only has to reach TIMEOUT_CLKS-2 before the abort decision.
    localparam int TMO_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    // The abort fires on the idle cycle whose increment would make the count
    // reach TIMEOUT_CLKS-1, so the error pulse lands TIMEOUT_CLKS cycles after
    // the last strobe.
    localparam logic [TMO_W-1:0] TMO_PRE   = TMO_W'(TIMEOUT_CLKS - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;

    logic             strobe;
    logic [7:0]       rx_byte;
    logic             handshake;
    logic             tmo_hit;
    logic [7:0]       chk_sum;

    // Datapath registers.
    logic [7:0]       len_q;
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] wr_idx_q;
    logic [IDX_W-1:0] rd_idx_q;
    logic [7:0]       acc_q;
    logic [TMO_W-1:0] tmo_q;
    logic [7:0]       buf_mem [MAX_LEN];

    // Next-cycle decisions from the control process.
    logic             ld_len;
    logic             wr_en;
    logic             rd_adv;
    logic             err_len_d, err_chk_d, err_tmo_d, drop_d;

    // Registered outputs.
    logic             valid_q;
    logic             busy_q;
    logic             err_len_q, err_chk_q, err_tmo_q, drop_q;
    logic [7:0]       pkt_len_q;

    assign strobe    = bus.i_Rx_DV;
    assign rx_byte   = bus.i_Rx_Byte;
    assign handshake = valid_q & bus.i_Pkt_Ready;
    assign tmo_hit   = !strobe && (tmo_q == TMO_PRE);
    assign chk_sum   = acc_q + rx_byte;

    // State register.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the strobe-driven datapath enables and error pulses.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
        state_d   = state_q;
        ld_len    = 1'b0;
        wr_en     = 1'b0;
        rd_adv    = 1'b0;
        err_len_d = 1'b0;
        err_chk_d = 1'b0;
        err_tmo_d = 1'b0;
        drop_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Anything other than the sync marker is line noise here.
                if (strobe && (rx_byte == SYNC_BYTE)) begin
                    state_d = S_LEN;
                end
            end

            S_LEN: begin
                if (strobe) begin
                    if ((rx_byte == 8'h00) || (rx_byte > MAX_LEN_B)) begin
                        err_len_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        ld_len  = 1'b1;
                        state_d = S_PAYLOAD;
                    end
                end else if (tmo_hit) begin
                    err_tmo_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end

            S_PAYLOAD: begin
                if (strobe) begin
                    wr_en = 1'b1;
                    if (wr_idx_q == last_q) begin
                        state_d = S_CHK;
                    end
                end else if (tmo_hit) begin
                    err_tmo_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end

            S_CHK: begin
                if (strobe) begin
                    if (chk_sum == 8'h00) begin
                        state_d = S_DRAIN;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end else if (tmo_hit) begin
                    err_tmo_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end

            S_DRAIN: begin
                // The buffer is busy replaying; new bytes, even SYNC, are lost.
                drop_d = strobe;
                if (handshake) begin
                    rd_adv = 1'b1;
                    if (rd_idx_q == last_q) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Length, checksum accumulator, buffer indices and inter-byte timeout counter.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
            len_q    <= 8'h00;
            last_q   <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            acc_q    <= 8'h00;
            tmo_q    <= '0;
        end else begin
            if (ld_len) begin
                len_q    <= rx_byte;
                last_q   <= IDX_W'(rx_byte - 8'd1);
                acc_q    <= rx_byte;
                wr_idx_q <= '0;
            end else if (wr_en) begin
                acc_q    <= acc_q + rx_byte;
                wr_idx_q <= wr_idx_q + 1'b1;
            end

            if ((state_q == S_CHK) && (state_d == S_DRAIN)) begin
                rd_idx_q <= '0;
            end else if (rd_adv) begin
                rd_idx_q <= rd_idx_q + 1'b1;
            end

            // Runs only while waiting for a byte inside a packet.
            if (strobe || (state_d != state_q) ||
                (state_q == S_IDLE) || (state_q == S_DRAIN)) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    // Payload buffer write port.
    always_ff @(posedge i_Clock) begin
        // NOTE: the buffer is deliberately not reset; it is only read after being written by a complete packet.
        if (wr_en) begin
            buf_mem[wr_idx_q] <= rx_byte;
        end
    end

    // Registered status, stream-valid and length outputs.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_len_q <= 1'b0;
            err_chk_q <= 1'b0;
            err_tmo_q <= 1'b0;
            drop_q    <= 1'b0;
            pkt_len_q <= 8'h00;
        end else begin
            valid_q   <= (state_d == S_DRAIN);
            busy_q    <= (state_d != S_IDLE);
            err_len_q <= err_len_d;
            err_chk_q <= err_chk_d;
            err_tmo_q <= err_tmo_d;
            drop_q    <= drop_d;
            // len_q cannot change while draining, so this holds for the whole drain.
            pkt_len_q <= (state_d == S_DRAIN) ? len_q : 8'h00;
        end
    end

    // Byte and last flag come straight from the registered read index; gated
    // by valid so the stream reads as zero whenever nothing is offered.
    assign bus.o_Pkt_Valid   = valid_q;
    assign bus.o_Pkt_Byte    = valid_q ? buf_mem[rd_idx_q] : 8'h00;
    assign bus.o_Pkt_Last    = valid_q && (rd_idx_q == last_q);
    assign bus.o_Pkt_Len     = pkt_len_q;
    assign bus.o_Busy        = busy_q;
    assign bus.o_Err_Len     = err_len_q;
    assign bus.o_Err_Chk     = err_chk_q;
    assign bus.o_Err_Timeout = err_tmo_q;
    assign bus.o_Drop        = drop_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Self-checking bench for uart_rx_pkt_ctrl: directed packet scenarios with
// cycle-exact checks, then randomized frames scored against a packet-level model.
module tb_uart_rx_pkt_ctrl;

    localparam int MAX_LEN = 16;
    localparam int T       = 3480;

    typedef logic [7:0] byte_t;

    logic clk   = 1'b0;
    logic rst_l = 1'b0;

    always #5 clk = ~clk;

    uart_rx_pkt_ctrl_if bus_if ();

    uart_rx_pkt_ctrl #(
        .MAX_LEN     (MAX_LEN),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CLKS(T)
    ) dut (
        .i_Clock(clk),
        .i_Rst_L(rst_l),
        .bus    (bus_if)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stream monitor: collects accepted bytes, counts pulse-high cycles and
    // checks the stream holds still under backpressure.
    byte_t got_q[$];
    bit    got_last_q[$];
    int    n_err_len, n_err_chk, n_err_tmo, n_drop;
    int    exp_len;
    logic  pv = 1'b0, pr = 1'b0, pl = 1'b0;
    byte_t pb = 8'h00;

    always @(negedge clk) begin
        if (bus_if.o_Err_Len)     n_err_len++;
        if (bus_if.o_Err_Chk)     n_err_chk++;
        if (bus_if.o_Err_Timeout) n_err_tmo++;
        if (bus_if.o_Drop)        n_drop++;
        if (rst_l && pv && !pr) begin
            check("hold_valid", bus_if.o_Pkt_Valid, 1'b1);
            check("hold_byte", bus_if.o_Pkt_Byte, pb);
            check("hold_last", bus_if.o_Pkt_Last, pl);
        end
        if (rst_l && bus_if.o_Pkt_Valid) begin
            check("pkt_len", bus_if.o_Pkt_Len, exp_len);
            if (bus_if.i_Pkt_Ready) begin
                got_q.push_back(bus_if.o_Pkt_Byte);
                got_last_q.push_back(bus_if.o_Pkt_Last);
            end
        end
        pv = bus_if.o_Pkt_Valid && rst_l;
        pr = bus_if.i_Pkt_Ready;
        pb = bus_if.o_Pkt_Byte;
        pl = bus_if.o_Pkt_Last;
    end

    // Consumer ready: 0 always high, 1 random, 2 pattern 0,0,1, 3 always low.
    int ready_mode = 0;
    int rcnt       = 0;

    initial begin
        bus_if.i_Pkt_Ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus_if.i_Pkt_Ready = 1'b1;
                1: bus_if.i_Pkt_Ready = 1'($urandom_range(0, 1));
                2: begin
                    bus_if.i_Pkt_Ready = (rcnt % 3 == 2);
                    rcnt++;
                end
                default: bus_if.i_Pkt_Ready = 1'b0;
            endcase
        end
    end

    task automatic send_byte(input byte_t b);
        @(posedge clk);
        #1;
        bus_if.i_Rx_DV   = 1'b1;
        bus_if.i_Rx_Byte = b;
        @(posedge clk);
        #1;
        bus_if.i_Rx_DV   = 1'b0;
        bus_if.i_Rx_Byte = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_frame(input byte_t q[$], input int max_gap);
        foreach (q[i]) begin
            if (i > 0 && max_gap > 0) idle($urandom_range(0, max_gap));
            send_byte(q[i]);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        got_last_q.delete();
        n_err_len = 0;
        n_err_chk = 0;
        n_err_tmo = 0;
        n_drop    = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (bus_if.o_Busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " idle"}, bus_if.o_Busy, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_result(input string tag, input byte_t exp_q[$],
                                 input int e_len, input int e_chk, input int e_tmo, input int e_drop);
        int n;
        check({tag, " n_bytes"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s byte%0d", tag, i), got_q[i], exp_q[i]);
            check($sformatf("%s last%0d", tag, i), got_last_q[i], (i == exp_q.size() - 1));
        end
        check({tag, " err_len"}, n_err_len, e_len);
        check({tag, " err_chk"}, n_err_chk, e_chk);
        check({tag, " err_tmo"}, n_err_tmo, e_tmo);
        check({tag, " drop"}, n_drop, e_drop);
    endtask

    // Checksum byte making (len + sum(payload) + chk) mod 256 == 0.
    function automatic byte_t chk_of(input byte_t p[$]);
        int s;
        s = p.size();
        foreach (p[i]) s += p[i];
        return 8'((256 - (s % 256)) % 256);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " valid"}, bus_if.o_Pkt_Valid, 1'b0);
        check({tag, " byte"}, bus_if.o_Pkt_Byte, 8'h00);
        check({tag, " last"}, bus_if.o_Pkt_Last, 1'b0);
        check({tag, " len"}, bus_if.o_Pkt_Len, 8'h00);
        check({tag, " busy"}, bus_if.o_Busy, 1'b0);
        check({tag, " err_len"}, bus_if.o_Err_Len, 1'b0);
        check({tag, " err_chk"}, bus_if.o_Err_Chk, 1'b0);
        check({tag, " err_tmo"}, bus_if.o_Err_Timeout, 1'b0);
        check({tag, " drop"}, bus_if.o_Drop, 1'b0);
    endtask

    task automatic good_packet(input string tag, input byte_t pay[$]);
        byte_t fr[$];
        clear_mon();
        exp_len = pay.size();
        fr = {8'hA5, 8'(pay.size())};
        foreach (pay[i]) fr.push_back(pay[i]);
        fr.push_back(chk_of(pay));
        send_frame(fr, 2);
        wait_idle(tag);
        expect_result(tag, pay, 0, 0, 0, 0);
    endtask

    initial begin
        byte_t fr[$], pay[$], expq[$];
        int    kind, len, sum, chk, e_len, e_chk, npre;
        byte_t g;
        string tag;

        bus_if.i_Rx_DV   = 1'b0;
        bus_if.i_Rx_Byte = 8'h00;
        clear_mon();
        exp_len = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst_l = 1'b1;

        // Good packet, ready high: cycle-exact drain.
        clear_mon();
        exp_len    = 3;
        ready_mode = 0;
        send_frame('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33}, 0);
        send_byte(8'h97);
        @(negedge clk);
        check("good v0", bus_if.o_Pkt_Valid, 1'b1);
        check("good b0", bus_if.o_Pkt_Byte, 8'h11);
        check("good l0", bus_if.o_Pkt_Last, 1'b0);
        check("good busy", bus_if.o_Busy, 1'b1);
        @(negedge clk);
        check("good b1", bus_if.o_Pkt_Byte, 8'h22);
        @(negedge clk);
        check("good b2", bus_if.o_Pkt_Byte, 8'h33);
        check("good l2", bus_if.o_Pkt_Last, 1'b1);
        @(negedge clk);
        check("good v_end", bus_if.o_Pkt_Valid, 1'b0);
        check("good busy_end", bus_if.o_Busy, 1'b0);
        wait_idle("good");
        expect_result("good", '{8'h11, 8'h22, 8'h33}, 0, 0, 0, 0);

        // Checksum error, then a clean packet.
        clear_mon();
        send_frame('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33}, 0);
        send_byte(8'h96);
        @(negedge clk);
        check("chkerr pulse", bus_if.o_Err_Chk, 1'b1);
        check("chkerr valid", bus_if.o_Pkt_Valid, 1'b0);
        check("chkerr busy", bus_if.o_Busy, 1'b0);
        wait_idle("chkerr");
        expect_result("chkerr", '{}, 0, 1, 0, 0);
        good_packet("after_chk", '{8'h5A, 8'hA5, 8'h00});

        // Length errors; trailing bytes ignored until the next sync.
        clear_mon();
        send_frame('{8'hA5}, 0);
        send_byte(8'h00);
        @(negedge clk);
        check("len0 pulse", bus_if.o_Err_Len, 1'b1);
        check("len0 busy", bus_if.o_Busy, 1'b0);
        send_frame('{8'h11, 8'h22, 8'h33}, 1);
        wait_idle("len0");
        expect_result("len0", '{}, 1, 0, 0, 0);
        clear_mon();
        send_frame('{8'hA5, 8'h11, 8'h02, 8'hAA, 8'hBB}, 1);
        wait_idle("len17");
        expect_result("len17", '{}, 1, 0, 0, 0);
        good_packet("after_len", '{8'h42});

        // Timeout: pulse exactly T cycles after the last strobe.
        clear_mon();
        send_frame('{8'hA5, 8'h02, 8'h11}, 0);
        for (int k = 1; k <= T; k++) begin
            @(negedge clk);
            if (k == T - 1) begin
                check("tmo early", bus_if.o_Err_Timeout, 1'b0);
                check("tmo busy_pre", bus_if.o_Busy, 1'b1);
            end
        end
        check("tmo pulse", bus_if.o_Err_Timeout, 1'b1);
        check("tmo busy", bus_if.o_Busy, 1'b0);
        @(negedge clk);
        check("tmo one_cycle", bus_if.o_Err_Timeout, 1'b0);
        expect_result("tmo", '{}, 0, 0, 1, 0);

        // Strobe on the terminal-count cycle is accepted instead.
        clear_mon();
        exp_len = 2;
        send_frame('{8'hA5, 8'h02, 8'h11}, 0);
        idle(T - 3);
        send_byte(8'h22);
        send_byte(8'hCB);
        wait_idle("tmo_edge");
        expect_result("tmo_edge", '{8'h11, 8'h22}, 0, 0, 0, 0);

        // Backpressure with ready 0,0,1 and a sync strobe dropped mid-drain.
        clear_mon();
        exp_len    = 4;
        rcnt       = 0;
        ready_mode = 2;
        send_frame('{8'hA5, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hC4}, 0);
        idle(2);
        send_byte(8'hA5);
        @(negedge clk);
        check("drop pulse", bus_if.o_Drop, 1'b1);
        wait_idle("bp");
        expect_result("bp", '{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 0, 0, 0, 1);
        ready_mode = 1;
        good_packet("after_drop", '{8'h01, 8'h02});

        // Reset in the middle of the payload.
        ready_mode = 0;
        clear_mon();
        send_frame('{8'hA5, 8'h04, 8'h11, 8'h22}, 0);
        @(posedge clk);
        #1 rst_l = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("rst_pay");
        @(posedge clk);
        #1 rst_l = 1'b1;
        wait_idle("rst_pay");
        expect_result("rst_pay", '{}, 0, 0, 0, 0);
        good_packet("after_rst_pay", '{8'h77, 8'h88, 8'h99});

        // Reset in the middle of a stalled drain.
        clear_mon();
        exp_len    = 3;
        ready_mode = 3;
        send_frame('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97}, 0);
        idle(3);
        @(negedge clk);
        check("rst_drain stalled", bus_if.o_Pkt_Valid, 1'b1);
        @(posedge clk);
        #1 rst_l = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("rst_drain");
        @(posedge clk);
        #1 rst_l = 1'b1;
        ready_mode = 0;
        wait_idle("rst_drain");
        expect_result("rst_drain", '{}, 0, 0, 0, 0);
        good_packet("after_rst_drain", '{8'hC3});

        // Randomized frames against the packet-level model.
        ready_mode = 1;
        for (int f = 0; f < 40; f++) begin
            fr.delete();
            pay.delete();
            expq.delete();
            clear_mon();
            tag   = $sformatf("rnd%0d", f);
            kind  = $urandom_range(0, 9);
            e_len = 0;
            e_chk = 0;
            npre  = $urandom_range(0, 3);
            for (int i = 0; i < npre; i++) begin
                do g = 8'($urandom); while (g == 8'hA5);
                fr.push_back(g);
            end
            fr.push_back(8'hA5);
            if (kind >= 8) begin
                len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
                fr.push_back(8'(len));
                e_len = 1;
                for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                    do g = 8'($urandom); while (g == 8'hA5);
                    fr.push_back(g);
                end
            end else begin
                len = $urandom_range(1, MAX_LEN);
                sum = 0;
                for (int i = 0; i < len; i++) begin
                    pay.push_back(8'($urandom));
                    sum += pay[i];
                end
                chk = chk_of(pay);
                if (kind >= 6) chk = (chk + $urandom_range(1, 255)) % 256;
                fr.push_back(8'(len));
                foreach (pay[i]) fr.push_back(pay[i]);
                fr.push_back(8'(chk));
                if ((len + sum + chk) % 256 == 0) expq = pay;
                else e_chk = 1;
            end
            exp_len = len;
            send_frame(fr, 4);
            wait_idle(tag);
            expect_result(tag, expq, e_len, e_chk, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_pkt_ctrl.md
# uart_rx_pkt_ctrl

Receive-side packet controller placed directly behind the UART receiver. It consumes the receiver's one-cycle byte strobes and frames them into length-prefixed, checksummed packets in a small internal buffer. Each validated packet is replayed to the downstream consumer over a valid/ready byte stream. Malformed, corrupted or stalled packets are discarded and reported on one-cycle error strobes.

## Interface
- MAX_LEN, 16: maximum payload length in bytes (1..255); sets buffer depth.
- SYNC_BYTE, 8'hA5: packet start marker.
- TIMEOUT_CLKS, 3480: idle clocks between bytes inside a packet before abort (default is 4 byte-times at 87 clocks/bit).

Ports:
- i_Clock  in  1  system clock; all logic on rising edge.
- i_Rst_L  in  1  synchronous, active-low reset.
- i_Rx_DV  in  1  receiver byte-valid strobe, one cycle per byte.
- i_Rx_Byte  in  8  received byte; sampled only when i_Rx_DV=1.
- o_Pkt_Valid  out  1  output byte valid.
- o_Pkt_Byte  out  8  output payload byte.
- o_Pkt_Last  out  1  marks the final payload byte; qualified by o_Pkt_Valid.
- i_Pkt_Ready  in  1  consumer accepts the byte when o_Pkt_Valid & i_Pkt_Ready.
- o_Pkt_Len  out  8  length of the packet being drained; held during DRAIN.
- o_Busy  out  1  high in every state except IDLE.
- o_Err_Len  out  1  one-cycle pulse: length byte was 0 or > MAX_LEN.
- o_Err_Chk  out  1  one-cycle pulse: checksum mismatch.
- o_Err_Timeout  out  1  one-cycle pulse: inter-byte timeout.
- o_Drop  out  1  one-cycle pulse: received byte discarded during DRAIN.

## Operation
- Packet format: SYNC_BYTE, LEN, LEN payload bytes, CHK. The frame is valid when (LEN + sum of payload + CHK) mod 256 == 0.
- State IDLE:
  - Each strobe with i_Rx_Byte==SYNC_BYTE goes to LEN.
  - Other bytes are silently ignored; no o_Drop.
- State LEN:
  - On strobe, if byte is 0 or > MAX_LEN: pulse o_Err_Len and go to IDLE.
  - Otherwise store the length, set checksum accumulator = byte, set write index = 0, and go to PAYLOAD.
- State PAYLOAD:
  - Each strobe writes buffer[write index], adds the byte to the 8-bit accumulator (wraps mod 256), and increments the index.
  - After byte LEN-1 is written, go to CHK.
- State CHK:
  - On strobe, if (accumulator + byte) mod 256 == 0: go to DRAIN with read index = 0.
  - Otherwise pulse o_Err_Chk and go to IDLE.
- Timeout (LEN, PAYLOAD, CHK only):
  - A counter clears on every strobe and on state entry, and increments every cycle without a strobe.
  - When it reaches TIMEOUT_CLKS-1: pulse o_Err_Timeout and go to IDLE.
  - A strobe in the same cycle as the terminal count wins; it is processed and no timeout fires.
- State DRAIN:
  - o_Pkt_Valid=1; o_Pkt_Byte=buffer[read index]; o_Pkt_Last=1 when read index==LEN-1.
  - Each handshake increments the read index. The handshake on the last byte returns to IDLE.
  - The timeout counter is inactive in DRAIN; backpressure may be unbounded.
  - Strobes arriving in DRAIN pulse o_Drop and are discarded, including SYNC_BYTE.
- Only one error pulse can occur per cycle; no two error conditions coincide.
- Reset:
  - All outputs go to 0, state goes to IDLE, counters and accumulator clear.
  - Buffer contents are don't-care.
  - Reset asserted mid-packet or mid-drain abandons the packet with no error pulse.

## Timing
- All outputs are registered, except that o_Pkt_Byte and o_Pkt_Last are decoded from the registered read index and buffer.
- State changes take effect the cycle after the triggering strobe.
- Error pulses are high exactly one cycle, starting the cycle after the triggering strobe or terminal count.
- Drain start latency: CHK strobe at cycle N gives o_Pkt_Valid=1 at N+1.
- With i_Pkt_Ready held high, one byte transfers per cycle: LEN cycles of valid, and IDLE at N+1+LEN.
- While i_Pkt_Ready=0, o_Pkt_Byte and o_Pkt_Last hold stable.
- o_Pkt_Valid drops the cycle after the last handshake.
- A SYNC_BYTE strobe in the cycle o_Busy falls is ignored, since the state is not yet IDLE on that edge.

## Test plan
- Good packet: A5 03 11 22 33 97 with ready high. Required: 3 valid beats 11,22,33; Last on 33; o_Pkt_Len=3; no error pulses.
- Checksum error: A5 03 11 22 33 96. Required: o_Err_Chk pulses once, no o_Pkt_Valid, controller back in IDLE. A following good packet is then delivered intact.
- Length errors: A5 00, and A5 11 with MAX_LEN=16. Required: o_Err_Len pulses once for each; bytes after the bad length are ignored until the next A5.
- Timeout: A5 02 11, then silence. Required: o_Err_Timeout pulses TIMEOUT_CLKS cycles after the 11 strobe, then IDLE. A strobe landing exactly on the terminal count is accepted instead.
- Backpressure and drop: good 4-byte packet with ready toggling 0,0,1 repeatedly. Required: bytes in order and held stable while ready=0. A strobe injected during DRAIN pulses o_Drop.
- Reset: assert i_Rst_L=0 mid-PAYLOAD and again mid-DRAIN. Required: all outputs 0 next cycle, no error pulse, and the next good packet is delivered correctly.
